qbus_slave_sequencer: RTL
=========================

Name: qbus_slave_sequencer

Overview:
- Sequences QBUS slave data cycles (DATI, DATO, DATIO) for up to NDEV on-board register devices, such as the switch register and the RK controller registers.
- Per cycle: latches which device matched at RSYNC, muxes that device's TDL onto the bus, produces the single-cycle write_pulse, and times TRPLY.
- Sits between the QBUS transceiver logic and the device register blocks, all clocked on qclk.

Parameters:
- NDEV, 4: number of attached devices, 1..8.
- RDLY, 3: qclk cycles from RDIN seen to TRPLY asserted (data setup), 1..15.
- WDLY, 1: qclk cycles from write_pulse to TRPLY asserted, 1..15.

Ports:
- qclk  in  1  20 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- RSYNC  in  1  bus SYNC, true-high, already buffered.
- RDIN  in  1  bus DIN, true-high.
- RDOUT  in  1  bus DOUT, true-high.
- dev_match  in  NDEV  per-device addr_match, valid while RSYNC is asserted.
- dev_tdl  in  16*NDEV  per-device read data; device i occupies bits [16i+15:16i].
- TDL  out  16  read data to the transceivers.
- tdl_oe  out  1  drive-enable for TDL onto the bus.
- TRPLY  out  1  bus RPLY request.
- write_pulse  out  NDEV  one-hot, one qclk wide; the selected device captures RDL.
- read_pulse  out  NDEV  one-hot, one qclk wide, at TRPLY assertion on a read (for read-clear side effects).
- sel_conflict  out  1  sticky; set when more than one dev_match bit is seen at a sync latch.

Behaviour:
- Reset: all outputs 0, state IDLE, sel cleared, counter 0. Reset asserted mid-cycle drops TRPLY and tdl_oe immediately (asynchronous).
- Selection: on the first qclk where RSYNC=1 in IDLE, latch sel = lowest-index set bit of dev_match.
  - If no bit is set, sel_valid=0 and go to IGNORE.
  - If two or more bits are set, set sel_conflict, which holds until reset.
- States and transitions:
  - IDLE: on RSYNC, go to ADDR, or to IGNORE if there is no match.
  - IGNORE: no outputs driven; go to IDLE when RSYNC=0.
  - ADDR: on RDIN, go to RSETUP and load counter=RDLY. On RDOUT, pulse write_pulse[sel] this cycle, load counter=WDLY, go to WWAIT. If RDIN and RDOUT are both seen, RDIN wins. On RSYNC=0, go to IDLE.
  - RSETUP: tdl_oe=1, TDL=dev_tdl[sel]; count down. At 0, assert TRPLY, pulse read_pulse[sel], go to RREPLY. If RDIN drops early, go to ADDR with no reply.
  - RREPLY: hold TRPLY, tdl_oe and TDL. When RDIN=0, drop TRPLY the next cycle, go to ADDR. tdl_oe stays 1 for one extra qclk (hold time), then 0.
  - WWAIT: count down; at 0, assert TRPLY, go to WREPLY.
  - WREPLY: hold TRPLY; when RDOUT=0, drop TRPLY and go to ADDR.
- DATIO: read then write within one RSYNC reuses the latched sel. write_pulse fires exactly once per RDOUT assertion.
- RSYNC dropping in any state except IGNORE: abort to IDLE and clear TRPLY, tdl_oe and the counter.
- TDL is 0 whenever tdl_oe=0.
- Latency: read TRPLY at RDLY+1 qclk after the first RDIN-high sample; write TRPLY at WDLY+1 qclk.

Optional Feature:
- Macro: QBUS_SYNC_FILTER_EN.
- Defined: RSYNC, RDIN and RDOUT pass through two-flop synchronizers before the FSM. All response latencies grow by 2 qclk.
- Undefined: inputs are used directly, and the caller guarantees they are synchronous to qclk.

Decomposition:
- Shared package qbus_pkg holds:
  - the state enum: IDLE, IGNORE, ADDR, RSETUP, RREPLY, WWAIT, WREPLY;
  - localparam QDW=16;
  - the delay counter width of 4.
- One natural sub-module, qbus_sync2: a two-flop synchronizer, instantiated three times when QBUS_SYNC_FILTER_EN is defined.

Test Plan:
- DATI, defaults, dev_match=4'b0100, dev_tdl[2]=16'o177570: RDIN -> TRPLY 4 qclk later, TDL=177570, read_pulse=4'b0100 for one qclk; RDIN drop -> TRPLY off next qclk, tdl_oe off one qclk later.
- DATO, dev_match=4'b0001: RDOUT -> write_pulse=4'b0001 for exactly one qclk, TRPLY 2 qclk later; RDOUT drop -> TRPLY off.
- No match, dev_match=0: RSYNC+RDIN held 20 qclk -> TRPLY, tdl_oe and write_pulse stay 0; RSYNC drop -> state IDLE.
- Conflict, dev_match=4'b1010: DATI returns dev_tdl[1] and sel_conflict=1; it stays 1 through the next clean cycle until reset.
- DATIO on dev 3: RDIN/reply/release, then RDOUT in the same RSYNC -> one write_pulse[3], with sel unchanged.
- Abort and reset: RSYNC drops during RSETUP -> no TRPLY, IDLE next cycle. reset asserted during RREPLY -> TRPLY=0 with no clock edge.

Source files
------------

// File: rtl/qbus_pkg.sv
// Shared types and widths for the QBUS slave data-cycle sequencer.
package qbus_pkg;

  localparam int unsigned QDW  = 16;
  localparam int unsigned CNTW = 4;

  typedef logic [CNTW-1:0] qbus_cnt_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IGNORE = 3'd1,
    ADDR   = 3'd2,
    RSETUP = 3'd3,
    RREPLY = 3'd4,
    WWAIT  = 3'd5,
    WREPLY = 3'd6
  } qbus_state_e;

endpackage

// File: rtl/qbus_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit bus strobe.
module qbus_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/qbus_slave_sequencer.sv
// QBUS slave data-cycle sequencer (DATI/DATO/DATIO) for NDEV register devices.
// Optional QBUS_SYNC_FILTER_EN adds two-flop synchronizers on RSYNC/RDIN/RDOUT.
module qbus_slave_sequencer
  import qbus_pkg::*;
#(
  parameter int unsigned NDEV = 4,
  parameter int unsigned RDLY = 3,
  parameter int unsigned WDLY = 1
) (
  input  logic                  qclk,
  input  logic                  reset,
  input  logic                  RSYNC,
  input  logic                  RDIN,
  input  logic                  RDOUT,
  input  logic [NDEV-1:0]       dev_match,
  input  logic [QDW*NDEV-1:0]   dev_tdl,
  output logic [QDW-1:0]        TDL,
  output logic                  tdl_oe,
  output logic                  TRPLY,
  output logic [NDEV-1:0]       write_pulse,
  output logic [NDEV-1:0]       read_pulse,
  output logic                  sel_conflict
);

  localparam int unsigned SELW = (NDEV > 1) ? $clog2(NDEV) : 1;

  logic rsync_s;
  logic rdin_s;
  logic rdout_s;

`ifdef QBUS_SYNC_FILTER_EN
  qbus_sync2 u_sync_rsync (.clk_i(qclk), .rst_i(reset), .d_i(RSYNC), .q_o(rsync_s));
  qbus_sync2 u_sync_rdin  (.clk_i(qclk), .rst_i(reset), .d_i(RDIN),  .q_o(rdin_s));
  qbus_sync2 u_sync_rdout (.clk_i(qclk), .rst_i(reset), .d_i(RDOUT), .q_o(rdout_s));
`else
  assign rsync_s = RSYNC;
  assign rdin_s  = RDIN;
  assign rdout_s = RDOUT;
`endif

  qbus_state_e         state_q, state_d;
  qbus_cnt_t           cnt_q, cnt_d;
  logic [SELW-1:0]     sel_q, sel_d;
  logic                conflict_q, conflict_d;
  logic                trply_q, trply_d;
  logic                oe_q, oe_d;
  logic [QDW-1:0]      tdl_q, tdl_d;
  logic [NDEV-1:0]     wp_q, wp_d;
  logic [NDEV-1:0]     rp_q, rp_d;

  logic [SELW-1:0]     first_idx_c;
  logic                any_match_c;
  logic                multi_match_c;
  logic [QDW-1:0]      sel_tdl_c;
  logic [NDEV-1:0]     sel_onehot_c;

  // Lowest-index priority pick of the address matchers
  always_comb begin
    first_idx_c   = '0;
    any_match_c   = |dev_match;
    multi_match_c = (dev_match & (dev_match - NDEV'(1))) != '0;
    for (int i = int'(NDEV) - 1; i >= 0; i--) begin
      if (dev_match[i]) first_idx_c = SELW'(i);
    end
  end

  assign sel_tdl_c    = dev_tdl[QDW*32'(sel_q) +: QDW];
  assign sel_onehot_c = NDEV'(1) << sel_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    conflict_d = conflict_q;
    trply_d    = trply_q;
    oe_d       = oe_q;
    wp_d       = '0;
    rp_d       = '0;

    if (state_q != IDLE && state_q != IGNORE && !rsync_s) begin
      state_d = IDLE;
      trply_d = 1'b0;
      oe_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          trply_d = 1'b0;
          oe_d    = 1'b0;
          cnt_d   = '0;
          if (rsync_s) begin
            sel_d = first_idx_c;
            if (multi_match_c) conflict_d = 1'b1;
            state_d = any_match_c ? ADDR : IGNORE;
          end
        end
        IGNORE: begin
          trply_d = 1'b0;
          oe_d    = 1'b0;
          if (!rsync_s) state_d = IDLE;
        end
        ADDR: begin
          // oe_q may still be high here for the post-read hold cycle
          trply_d = 1'b0;
          oe_d    = 1'b0;
          if (rdin_s) begin
            state_d = RSETUP;
            cnt_d   = qbus_cnt_t'(RDLY);
            oe_d    = 1'b1;
          end else if (rdout_s) begin
            wp_d    = sel_onehot_c;
            cnt_d   = qbus_cnt_t'(WDLY);
            state_d = WWAIT;
          end
        end
        RSETUP: begin
          oe_d = 1'b1;
          if (!rdin_s) begin
            state_d = ADDR;
            oe_d    = 1'b0;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            trply_d = 1'b1;
            rp_d    = sel_onehot_c;
            state_d = RREPLY;
          end else begin
            cnt_d = cnt_q - qbus_cnt_t'(1);
          end
        end
        RREPLY: begin
          oe_d = 1'b1;
          if (!rdin_s) begin
            trply_d = 1'b0;
            state_d = ADDR;
          end
        end
        WWAIT: begin
          if (cnt_q == '0) begin
            trply_d = 1'b1;
            state_d = WREPLY;
          end else begin
            cnt_d = cnt_q - qbus_cnt_t'(1);
          end
        end
        WREPLY: begin
          if (!rdout_s) begin
            trply_d = 1'b0;
            state_d = ADDR;
          end
        end
        default: begin
          state_d = IDLE;
          trply_d = 1'b0;
          oe_d    = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end

    tdl_d = oe_d ? sel_tdl_c : '0;
  end

  always_ff @(posedge qclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      conflict_q <= 1'b0;
      trply_q    <= 1'b0;
      oe_q       <= 1'b0;
      tdl_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      conflict_q <= conflict_d;
      trply_q    <= trply_d;
      oe_q       <= oe_d;
      tdl_q      <= tdl_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
    end
  end

  assign TDL          = tdl_q;
  assign tdl_oe       = oe_q;
  assign TRPLY        = trply_q;
  assign write_pulse  = wp_q;
  assign read_pulse   = rp_q;
  assign sel_conflict = conflict_q;

endmodule
